// File: rtl/alu_logic_pipe.sv
// Pipelined logic/shift/LUI ALU with a destination tag, valid/ready handshake and flush.
// The result is computed at accept into stage 0; later stages only carry it forward.
module alu_logic_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5,
  localparam int OCC_W = $clog2(STAGES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_op,
  input  logic [WIDTH-1:0]   in_src_left,
  input  logic [WIDTH-1:0]   in_src_right,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [TAG_W-1:0]   out_tag,
  output logic [OCC_W-1:0]   occupancy
);

  localparam int SA_W = $clog2(WIDTH);
  localparam int HALF = WIDTH / 2;

  logic [STAGES-1:0] valid_reg;
  logic [STAGES-1:0] valid_next;
  logic [WIDTH-1:0]  result_reg [STAGES];
  logic [TAG_W-1:0]  tag_reg    [STAGES];
  logic [STAGES:0]   ready;
  logic [OCC_W-1:0]  occ_reg;
  logic [OCC_W-1:0]  occ_next;
  logic [WIDTH-1:0]  alu_result;
  logic [SA_W-1:0]   sa;
  logic              accept;
  logic              unused_bits;

  assign sa          = in_src_left[SA_W-1:0];
  assign unused_bits = ^in_src_left[WIDTH-1:SA_W];

  always_comb begin
    alu_result = '0;
    case (in_op)
      4'd0: alu_result = in_src_left & in_src_right;
      4'd1: alu_result = in_src_left | in_src_right;
      4'd2: alu_result = in_src_left ^ in_src_right;
      4'd3: alu_result = ~(in_src_left | in_src_right);
      4'd4: alu_result = {in_src_right[HALF-1:0], {HALF{1'b0}}};
      4'd5: alu_result = in_src_right << sa;
      4'd6: alu_result = in_src_right >> sa;
      4'd7: alu_result = $signed(in_src_right) >>> sa;
      default: alu_result = '0;
    endcase
  end

  // Stage k can take data when any stage from k to the end is empty or the
  // consumer is draining; written in closed form to keep the chain acyclic.
  assign ready[STAGES] = out_ready;
  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_ready
      assign ready[gi] = out_ready || !(&valid_reg[STAGES-1:gi]);
    end
  endgenerate

  assign in_ready = ready[0] && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_next = valid_reg;
    if (flush) begin
      valid_next = '0;
    end else begin
      if (ready[0]) valid_next[0] = accept;
      for (int k = 1; k < STAGES; k++) begin
        if (ready[k]) valid_next[k] = valid_reg[k-1];
      end
    end
  end

  always_comb begin
    occ_next = '0;
    for (int k = 0; k < STAGES; k++) begin
      occ_next = occ_next + OCC_W'(valid_next[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
      occ_reg   <= '0;
    end else begin
      valid_reg <= valid_next;
      occ_reg   <= occ_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_reg[0] <= '0;
      tag_reg[0]    <= '0;
    end else if (accept) begin
      result_reg[0] <= alu_result;
      tag_reg[0]    <= in_tag;
    end
  end

  // Data registers only load on a real transfer, so a flushed or drained
  // output keeps showing its last result.
  generate
    for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          result_reg[gi] <= '0;
          tag_reg[gi]    <= '0;
        end else if (!flush && ready[gi] && valid_reg[gi-1]) begin
          result_reg[gi] <= result_reg[gi-1];
          tag_reg[gi]    <= tag_reg[gi-1];
        end
      end
    end
  endgenerate

  assign out_valid  = valid_reg[STAGES-1];
  assign out_result = result_reg[STAGES-1];
  assign out_tag    = tag_reg[STAGES-1];
  assign occupancy  = occ_reg;

endmodule

// File: tb/tb_alu_logic_pipe.sv
// Self-checking bench for alu_logic_pipe: directed scenarios plus a randomized
// stream, all scored against an in-order queue model of the ALU.
module tb_alu_logic_pipe;
  localparam int W  = 32;
  localparam int S  = 2;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_op = '0;
  logic [W-1:0]  in_src_left = '0;
  logic [W-1:0]  in_src_right = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_result;
  logic [TW-1:0] out_tag;
  logic [1:0]    occupancy;

  typedef struct packed {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t          q[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic          stall_seen = 1'b0;
  logic [W-1:0]  stall_res;
  logic [TW-1:0] stall_tag;

  alu_logic_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src_left(in_src_left), .in_src_right(in_src_right), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] l,
                                         input logic [W-1:0] r);
    int sa;
    logic [W-1:0] m;
    sa = int'(l % W);
    case (op)
      4'd0: return l & r;
      4'd1: return l | r;
      4'd2: return l ^ r;
      4'd3: return ~(l | r);
      4'd4: return r << (W / 2);
      4'd5: return r << sa;
      4'd6: return r >> sa;
      4'd7: begin
        m = r >> sa;
        if (r[W-1]) m = m | ~({W{1'b1}} >> sa);
        return m;
      end
      default: return '0;
    endcase
  endfunction

  // One clock: sample just before the rising edge, score, then wait for the falling edge.
  task automatic tick();
    exp_t e;
    #2;
    if (stall_seen) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_result !== stall_res || out_tag !== stall_tag) begin
        n_err++;
        $display("FAIL hold: valid=%b result=%h tag=%h, required 1 %h %h",
                 out_valid, out_result, out_tag, stall_res, stall_tag);
      end
    end
    stall_seen = out_valid && !out_ready && !flush;
    stall_res  = out_result;
    stall_tag  = out_tag;
    if (!flush && out_valid && out_ready) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: result=%h tag=%h, required no output", out_result, out_tag);
      end else begin
        e = q.pop_front();
        if (out_result !== e.res || out_tag !== e.tag) begin
          n_err++;
          $display("FAIL result: got %h tag %h, required %h tag %h", out_result, out_tag, e.res, e.tag);
        end else begin
          $display("out result=%h tag=%h", out_result, out_tag);
        end
      end
    end
    if (flush) q.delete();
    else if (in_valid && in_ready) q.push_back('{res: model(in_op, in_src_left, in_src_right), tag: in_tag});
    @(negedge clk);
  endtask

  task automatic rand_op();
    in_op        = 4'($urandom_range(0, 15));
    in_src_left  = $urandom();
    in_src_right = $urandom();
    in_tag       = TW'($urandom());
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || out_result !== '0 || out_tag !== '0 || occupancy !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state: valid=%b result=%h tag=%h occ=%0d, required all 0",
               out_valid, out_result, out_tag, occupancy);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_logic();
    logic [W-1:0] expv [4] = '{32'h00F0_000F, 32'hFFF0_FFFF, 32'hFF00_FFF0, 32'h000F_0000};
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (cyc < 4) begin
        in_valid = 1'b1; in_op = 4'(cyc); in_tag = TW'(cyc + 1);
        in_src_left = 32'hF0F0_00FF; in_src_right = 32'h0FF0_FF0F;
      end else in_valid = 1'b0;
      #1;
      n_vec++;
      if (cyc < 2) begin
        if (out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL logic_latency: out_valid=%b at cycle %0d, required 0", out_valid, cyc);
        end
      end else if (out_valid !== 1'b1 || out_result !== expv[cyc-2] || out_tag !== TW'(cyc - 1)) begin
        n_err++;
        $display("FAIL logic_op%0d: valid=%b result=%h tag=%0d, required 1 %h %0d",
                 cyc - 2, out_valid, out_result, out_tag, expv[cyc-2], cyc - 1);
      end
      tick();
    end
  endtask

  task automatic test_shift_lui();
    logic [3:0]   ops  [5] = '{4'd4, 4'd7, 4'd6, 4'd5, 4'd9};
    logic [W-1:0] lv   [5] = '{32'h0, 32'h4, 32'h4, 32'h25, 32'hFFFF_FFFF};
    logic [W-1:0] rv   [5] = '{32'h1234_ABCD, 32'h8000_0000, 32'h8000_0000, 32'h1, 32'hFFFF_FFFF};
    logic [W-1:0] expv [5] = '{32'hABCD_0000, 32'hF800_0000, 32'h0800_0000, 32'h20, 32'h0};
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 7; cyc++) begin
      if (cyc < 5) begin
        in_valid = 1'b1; in_op = ops[cyc]; in_tag = TW'(cyc + 10);
        in_src_left = lv[cyc]; in_src_right = rv[cyc];
      end else in_valid = 1'b0;
      #1;
      if (cyc >= 2) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_result !== expv[cyc-2] || out_tag !== TW'(cyc + 8)) begin
          n_err++;
          $display("FAIL shift_op%0d: valid=%b result=%h tag=%0d, required 1 %h %0d",
                   cyc - 2, out_valid, out_result, out_tag, expv[cyc-2], cyc + 8);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [3:0]    b_op [6];
    logic [W-1:0]  b_l  [6];
    logic [W-1:0]  b_r  [6];
    int            idx = 0;
    logic          acc;
    for (int i = 0; i < 6; i++) begin
      b_op[i] = 4'($urandom_range(0, 8)); b_l[i] = $urandom(); b_r[i] = $urandom();
    end
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      in_valid = 1'b1; in_op = b_op[idx]; in_src_left = b_l[idx]; in_src_right = b_r[idx];
      in_tag = TW'(idx + 20);
      #1;
      if (cyc >= 2) begin
        n_vec++;
        if (in_ready !== 1'b0 || occupancy !== 2'd2) begin
          n_err++;
          $display("FAIL bp_full: in_ready=%b occ=%0d, required 0 2", in_ready, occupancy);
        end
      end
      acc = in_ready;
      tick();
      if (acc) idx++;
    end
    n_vec++;
    if (idx != S) begin
      n_err++;
      $display("FAIL bp_accepts: accepted %0d, required %0d", idx, S);
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      in_valid = (idx < 6);
      if (idx < 6) begin
        in_op = b_op[idx]; in_src_left = b_l[idx]; in_src_right = b_r[idx]; in_tag = TW'(idx + 20);
      end
      #1;
      n_vec++;
      if (out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL bp_drain: out_valid=%b at drain cycle %0d, required 1", out_valid, cyc);
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    #1;
    n_vec++;
    if (idx != 6 || q.size() != 0) begin
      n_err++;
      $display("FAIL bp_total: accepted %0d pending %0d, required 6 0", idx, q.size());
    end
  endtask

  task automatic test_bubble();
    out_ready = 1'b0;
    in_valid = 1'b1; rand_op();
    tick();
    in_valid = 1'b0;
    tick();
    #1;
    n_vec++;
    if (occupancy !== 2'd1 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bubble_pre: occ=%0d valid=%b, required 1 1", occupancy, out_valid);
    end
    in_valid = 1'b1; rand_op();
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bubble_ready: in_ready=%b, required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    #1;
    n_vec++;
    if (occupancy !== 2'd2) begin
      n_err++;
      $display("FAIL bubble_occ: occ=%0d, required 2", occupancy);
    end
    out_ready = 1'b1;
    repeat (3) tick();
    n_vec++;
    if (occupancy !== 2'd0 || q.size() != 0) begin
      n_err++;
      $display("FAIL bubble_drain: occ=%0d pending=%0d, required 0 0", occupancy, q.size());
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] held;
    logic [TW-1:0] tagx;
    out_ready = 1'b0;
    in_valid = 1'b1; rand_op(); tick();
    rand_op(); tick();
    #1;
    n_vec++;
    if (occupancy !== 2'd2) begin
      n_err++;
      $display("FAIL flush_pre: occ=%0d, required 2", occupancy);
    end
    held = out_result;
    flush = 1'b1; out_ready = 1'b1; rand_op();
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL flush_ready: in_ready=%b, required 0", in_ready);
    end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_result !== held) begin
      n_err++;
      $display("FAIL flush_post: valid=%b occ=%0d result=%h, required 0 0 %h",
               out_valid, occupancy, out_result, held);
    end
    in_valid = 1'b1; rand_op(); tagx = in_tag;
    tick();
    in_valid = 1'b0;
    tick();
    #1;
    n_vec++;
    if (out_valid !== 1'b1 || out_tag !== tagx) begin
      n_err++;
      $display("FAIL flush_next: valid=%b tag=%0d, required 1 %0d", out_valid, out_tag, tagx);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_op = 4'd1; in_src_left = 32'hA5A5_0001; in_src_right = 32'h0; in_tag = 5'd3;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_result !== '0 || out_tag !== '0 || occupancy !== 2'd0) begin
      n_err++;
      $display("FAIL async_reset: valid=%b result=%h tag=%h occ=%0d, required all 0",
               out_valid, out_result, out_tag, occupancy);
    end
    q.delete();
    stall_seen = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      #1;
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      rand_op();
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 10 && q.size() != 0; cyc++) tick();
    n_vec++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL random_drain: pending=%0d out_valid=%b, required 0 0", q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_logic();
    test_shift_lui();
    test_backpressure();
    test_bubble();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_logic_pipe.md
Name: alu_logic_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle logic ALU in the EX stage.
- Executes the bitwise, LUI and shift operations on WIDTH-bit operands.
- Carries a destination tag alongside each result and supports downstream backpressure and a pipeline flush.
- Sits between the ID/EX register and the EX/MEM write-back arbiter.

Parameters:
WIDTH, 32, operand/result width in bits; even, >=8, power of two.
STAGES, 2, pipeline depth = latency in cycles with no backpressure; >=1.
TAG_W, 5, width of the opaque destination tag carried with each operation.

Ports:
clk  input  1  clock, all state on rising edge.
rst  input  1  asynchronous, active-high reset.
flush  input  1  synchronous kill of all in-flight operations.
in_valid  input  1  operation presented.
in_ready  output  1  unit accepts an operation this cycle.
in_op  input  4  operation code (see Behaviour).
in_src_left  input  WIDTH  left operand / shift amount source.
in_src_right  input  WIDTH  right operand / shift value.
in_tag  input  TAG_W  destination tag, passed through unchanged.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts the result this cycle.
out_result  output  WIDTH  result.
out_tag  output  TAG_W  tag of the result.
occupancy  output  clog2(STAGES+1)  number of valid stages.

Behaviour:
- Reset (async, rst=1): all stage valid bits 0, out_valid=0, out_result=0, out_tag=0, occupancy=0. in_ready reads 1 once rst deasserts.
- Op codes:
  - 0 AND: L&R. 1 OR: L|R. 2 XOR: L^R. 3 NOR: ~(L|R).
  - 4 LUI: {R[WIDTH/2-1:0], WIDTH/2 zeros}.
  - 5 SLL: R << sa. 6 SRL: R >> sa (logical). 7 SRA: R >>> sa (arithmetic, sign = R[WIDTH-1]).
  - sa = L[clog2(WIDTH)-1:0].
  - 8-15: result 0; the operation is still accepted and tagged.
- Result is computed combinationally at accept and registered into stage 0. Later stages only hold and move data.
- Handshake:
  - Accept when in_valid && in_ready.
  - Stage k advances when stage k+1 is empty or advancing. The last stage advances when out_ready.
  - in_ready = !stage0_valid || stage0 advancing, so it is purely combinational from out_ready and the valid bits.
  - Bubbles collapse: an empty stage is filled even while a later stage is stalled.
- Latency: with out_ready held 1, an operation accepted on edge N appears with out_valid=1 after edge N+STAGES-1. The result is visible STAGES cycles after presentation. Throughput is 1 per cycle.
- Output stability: while out_valid && !out_ready, out_result and out_tag hold unchanged and out_valid stays 1.
- Ordering: results leave in acceptance order. No reordering or dropping except by flush.
- Flush:
  - On an edge with flush=1, all valid bits clear; occupancy=0 next cycle.
  - in_ready is forced 0 during flush; an in_valid in that cycle is not accepted.
  - out_result/out_tag keep their last values but out_valid=0.
  - Flush overrides simultaneous out_ready.
- occupancy: registered count of valid stages, 0..STAGES. It updates on the same edge as the valid bits.
- STAGES=1: single register; in_ready = !valid || out_ready. Full throughput when out_ready=1.
- Reset mid-operation: all in-flight operations are discarded immediately (async); nothing is emitted after release.

Test Plan:
- AND/OR/XOR/NOR with L=0xF0F0_00FF, R=0x0FF0_FF0F (WIDTH=32, STAGES=2), out_ready=1 -> results 0x00F0_000F, 0xFFF0_FFFF, 0xFF00_FFF0, 0x000F_0000, each 2 cycles after presentation, back-to-back, tags preserved.
- LUI R=0x1234_ABCD -> 0xABCD_0000. SRA R=0x8000_0000, L=4 -> 0xF800_0000. SRL same operands -> 0x0800_0000. SLL R=1, L=0x25 (sa=5) -> 0x20. op=9 -> 0.
- Backpressure: stream 6 ops with out_ready=0 -> in_ready falls after STAGES accepts, occupancy=2, out_result stable. Raise out_ready -> all 6 results drain in order, one per cycle.
- Bubble collapse: stall output with only the last stage full, present a new op -> accepted (in_ready=1), occupancy goes 1->2.
- Flush with occupancy=2 and in_valid=1 -> next cycle out_valid=0, occupancy=0, flushed op never appears. The next op issues normally.
- Async reset asserted mid-stream between clock edges -> outputs go to 0 immediately. After release, in_ready=1 and no stale results emerge.
